// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one i2cmaster between NREQ requesters.
// Requesters are granted round-robin, one single-byte transaction is run on
// the master per grant (retried on ACK error) and the outcome is returned on
// a shared response port.
//
// state    | meaning
// IDLE     | waiting for a request; grants and latches the round-robin winner
// LAUNCH   | first cycle of an attempt, new_dat raised toward the master
// WAIT_HI  | new_dat held until the master reports busy
// WAIT_LO  | transfer in flight, waiting for busy to drop
// CHECK    | evaluates the captured ack error: retry, NACK or ok
// RESP     | one-cycle response pulse, round-robin pointer advanced
module i2c_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [2:0]        rsp_id,
  output logic [1:0]        rsp_status,
  output logic [7:0]        rsp_rdata,
  output logic              m_new_dat,
  output logic [6:0]        m_addr,
  output logic              m_r_w,
  output logic [7:0]        m_dat_in,
  input  logic [7:0]        m_dat_out,
  input  logic              m_busy,
  input  logic              m_ack_err,
  output logic              arb_busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_WAIT_HI, ST_WAIT_LO, ST_CHECK, ST_RESP
  } state_t;

  // Wait timers count down from TIMEOUT-1; reaching 0 in a wait state is the
  // TIMEOUT-th cycle spent there.
  localparam logic [15:0] TMR_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [2:0]  LAST_RST  = 3'(NREQ - 1);
  localparam logic [1:0]  RSP_OK    = 2'b00;
  localparam logic [1:0]  RSP_NACK  = 2'b01;
  localparam logic [1:0]  RSP_TMO   = 2'b10;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [2:0]  last_id_q, last_id_d;
  logic [2:0]  id_q, id_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] tmr_q, tmr_d;
  logic [3:0]  retry_q, retry_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  logic        hi_vld, lo_vld, sel_vld;
  logic [2:0]  hi_id, lo_id, sel_id;
  logic [6:0]  sel_addr;
  logic        sel_rw;
  logic [7:0]  sel_wdata;
  logic        grant_fire;
  logic        tmr_done;
  logic        retry_left;

  // armed_q holds grants off until the first clock after reset release, so
  // gnt cannot follow req combinationally while rst is low.
  assign grant_fire = armed_q && sel_vld;
  assign tmr_done   = (tmr_q == 16'd0);
  assign retry_left = (retry_q < RETRY_MAX);

  // Round-robin pick: first request above last_id, else first at or below it.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = 3'd0;
    lo_vld = 1'b0;
    lo_id  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (3'(i) > last_id_q) && !hi_vld) begin
        hi_vld = 1'b1;
        hi_id  = 3'(i);
      end
      if (req[i] && (3'(i) <= last_id_q) && !lo_vld) begin
        lo_vld = 1'b1;
        lo_id  = 3'(i);
      end
    end
    sel_vld = hi_vld | lo_vld;
    sel_id  = hi_vld ? hi_id : lo_id;
  end

  // Request field mux for the selected requester.
  always_comb begin
    sel_addr  = 7'd0;
    sel_rw    = 1'b0;
    sel_wdata = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == 3'(i)) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_fire) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (m_busy)        state_d = ST_WAIT_LO;
        else if (tmr_done) state_d = ST_RESP;
      end
      ST_WAIT_LO: begin
        if (!m_busy)       state_d = ST_CHECK;
        else if (tmr_done) state_d = ST_RESP;
      end
      ST_CHECK:   state_d = (ack_err_q && retry_left) ? ST_LAUNCH : ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latched request, timer, retries, capture, response.
  always_comb begin
    armed_d      = 1'b1;
    last_id_d    = last_id_q;
    id_d         = id_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    tmr_d        = tmr_q;
    retry_d      = retry_q;
    ack_err_d    = ack_err_q;
    rx_d         = rx_q;
    rsp_id_d     = rsp_id_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          id_d    = sel_id;
          addr_d  = sel_addr;
          rw_d    = sel_rw;
          wdata_d = sel_wdata;
          retry_d = 4'd0;
        end
      end
      ST_LAUNCH: tmr_d = TMR_LOAD;
      ST_WAIT_HI: begin
        if (m_busy) begin
          tmr_d = TMR_LOAD;
        end else if (tmr_done) begin
          rsp_id_d     = id_q;
          rsp_status_d = RSP_TMO;
          rsp_rdata_d  = 8'd0;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!m_busy) begin
          ack_err_d = m_ack_err;
          rx_d      = m_dat_out;
        end else if (tmr_done) begin
          rsp_id_d     = id_q;
          rsp_status_d = RSP_TMO;
          rsp_rdata_d  = 8'd0;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      ST_CHECK: begin
        if (ack_err_q && retry_left) begin
          retry_d = retry_q + 4'd1;
        end else if (ack_err_q) begin
          rsp_id_d     = id_q;
          rsp_status_d = RSP_NACK;
          rsp_rdata_d  = 8'd0;
        end else begin
          rsp_id_d     = id_q;
          rsp_status_d = RSP_OK;
          rsp_rdata_d  = rw_q ? rx_q : 8'd0;
        end
      end
      ST_RESP: last_id_d = id_q;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q      <= 1'b0;
      last_id_q    <= LAST_RST;
      id_q         <= 3'd0;
      addr_q       <= 7'd0;
      rw_q         <= 1'b0;
      wdata_q      <= 8'd0;
      tmr_q        <= 16'd0;
      retry_q      <= 4'd0;
      ack_err_q    <= 1'b0;
      rx_q         <= 8'd0;
      rsp_id_q     <= 3'd0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= 8'd0;
    end else begin
      armed_q      <= armed_d;
      last_id_q    <= last_id_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      tmr_q        <= tmr_d;
      retry_q      <= retry_d;
      ack_err_q    <= ack_err_d;
      rx_q         <= rx_d;
      rsp_id_q     <= rsp_id_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    gnt = '0;
    if (state_q == ST_IDLE && grant_fire) begin
      for (int i = 0; i < NREQ; i++) begin
        if (sel_id == 3'(i)) gnt[i] = 1'b1;
      end
    end
    m_new_dat  = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_HI);
    arb_busy   = (state_q != ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
    rsp_id     = rsp_id_q;
    rsp_status = rsp_status_q;
    rsp_rdata  = rsp_rdata_q;
    m_addr     = addr_q;
    m_r_w      = rw_q;
    m_dat_in   = wdata_q;
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a behavioural i2cmaster drives the main
// instance; a second instance with TIMEOUT=16 has a master that never answers.
module tb_i2c_req_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NREQ-1:0]   req, req_rw, gnt;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic              rsp_valid, m_new_dat, m_r_w, m_busy, m_ack_err, arb_busy;
  logic [2:0]        rsp_id;
  logic [1:0]        rsp_status;
  logic [7:0]        rsp_rdata, m_dat_in, m_dat_out;
  logic [6:0]        m_addr;

  logic [NREQ-1:0]   to_req, to_req_rw, to_gnt;
  logic [7*NREQ-1:0] to_req_addr;
  logic [8*NREQ-1:0] to_req_wdata;
  logic              to_rsp_valid, to_m_new_dat, to_m_r_w, to_m_busy, to_m_ack_err, to_arb_busy;
  logic [2:0]        to_rsp_id;
  logic [1:0]        to_rsp_status;
  logic [7:0]        to_rsp_rdata, to_m_dat_in, to_m_dat_out;
  logic [6:0]        to_m_addr;

  i2c_req_arbiter #(.NREQ(NREQ), .MAX_RETRY(2), .TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_status(rsp_status), .rsp_rdata(rsp_rdata), .m_new_dat(m_new_dat),
    .m_addr(m_addr), .m_r_w(m_r_w), .m_dat_in(m_dat_in), .m_dat_out(m_dat_out),
    .m_busy(m_busy), .m_ack_err(m_ack_err), .arb_busy(arb_busy)
  );

  i2c_req_arbiter #(.NREQ(NREQ), .MAX_RETRY(2), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .req(to_req), .req_addr(to_req_addr), .req_rw(to_req_rw),
    .req_wdata(to_req_wdata), .gnt(to_gnt), .rsp_valid(to_rsp_valid), .rsp_id(to_rsp_id),
    .rsp_status(to_rsp_status), .rsp_rdata(to_rsp_rdata), .m_new_dat(to_m_new_dat),
    .m_addr(to_m_addr), .m_r_w(to_m_r_w), .m_dat_in(to_m_dat_in), .m_dat_out(to_m_dat_out),
    .m_busy(to_m_busy), .m_ack_err(to_m_ack_err), .arb_busy(to_arb_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int n_gnt   = 0;

  // Event counters for grants and responses on the main instance.
  always @(negedge clk) begin
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (|gnt)      n_gnt <= n_gnt + 1;
  end

  // Master model: busy rises one cycle after new_dat is seen, stays high
  // busy_len cycles, then ack_err/dat_out are presented as busy drops.
  int         mst_st   = 0;
  int         mst_cnt  = 0;
  int         n_launch = 0;
  int         busy_len = 4;
  logic       cfg_ack_err = 1'b0;
  logic [7:0] cfg_rdata   = 8'h00;

  initial begin
    m_busy = 1'b0; m_ack_err = 1'b0; m_dat_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        m_busy = 1'b0; m_ack_err = 1'b0; m_dat_out = 8'h00; mst_st = 0;
      end else begin
        case (mst_st)
          0: if (m_new_dat) begin n_launch++; mst_st = 1; end
          1: begin m_busy = 1'b1; m_ack_err = 1'b0; mst_cnt = busy_len; mst_st = 2; end
          default: begin
            mst_cnt--;
            if (mst_cnt == 0) begin
              m_busy = 1'b0; m_ack_err = cfg_ack_err; m_dat_out = cfg_rdata; mst_st = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requester i posts a transaction (fields plus req bit).
  task automatic post(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    logic [7*NREQ-1:0] am, av;
    logic [8*NREQ-1:0] wm, wv;
    logic [NREQ-1:0]   b;
    am = {{(7*NREQ-7){1'b0}}, 7'h7F} << (7*idx);
    av = {{(7*NREQ-7){1'b0}}, a} << (7*idx);
    wm = {{(8*NREQ-8){1'b0}}, 8'hFF} << (8*idx);
    wv = {{(8*NREQ-8){1'b0}}, wd} << (8*idx);
    b  = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    req_addr  = (req_addr & ~am) | av;
    req_wdata = (req_wdata & ~wm) | wv;
    req_rw    = rw ? (req_rw | b) : (req_rw & ~b);
    req       = req | b;
  endtask

  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp, output logic [NREQ-1:0] seen);
    seen = '0;
    for (int c = 0; c < 200 && seen == '0; c++) begin
      @(negedge clk);
      seen = gnt;
    end
    chk(tag, 32'(seen), 32'(exp));
  endtask

  // Requester drops req on the cycle after its grant.
  task automatic drop(input logic [NREQ-1:0] seen);
    @(posedge clk); #1;
    req = req & ~seen;
  endtask

  task automatic wait_rsp(input string tag, input logic [2:0] eid, input logic [1:0] est, input logic [7:0] erd);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk({tag, "_valid"},  32'(got), 32'd1);
    chk({tag, "_id"},     32'(rsp_id), 32'(eid));
    chk({tag, "_status"}, 32'(rsp_status), 32'(est));
    chk({tag, "_rdata"},  32'(rsp_rdata), 32'(erd));
  endtask

  logic [NREQ-1:0] seen;
  int g0, l0, r0, lat;
  logic [NREQ-1:0] fair_gnt [4];
  logic [2:0]      fair_id  [4];

  initial begin
    rst = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    to_req = '0; to_req_rw = '0; to_req_addr = '0; to_req_wdata = '0;
    to_m_busy = 1'b0; to_m_ack_err = 1'b0; to_m_dat_out = 8'h00;
    fair_gnt = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    fair_id  = '{3'd0, 3'd2, 3'd0, 3'd2};

    // Reset state, with req[0] already asserted: no grant while rst is low.
    busy_len = 40; cfg_rdata = 8'h3C; cfg_ack_err = 1'b0;
    post(0, 7'h78, 1'b0, 8'hFF);
    repeat (3) @(negedge clk);
    chk("rst_gnt",       32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_m_new_dat", 32'(m_new_dat), 32'd0);
    chk("rst_m_addr",    32'(m_addr), 32'd0);
    chk("rst_arb_busy",  32'(arb_busy), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // T1: write 0x78 <- 0xFF from requester 0, busy 40 cycles, ack ok.
    g0 = n_gnt; l0 = n_launch;
    wait_gnt("t1_gnt", 4'b0001, seen);
    drop(seen);
    @(negedge clk);
    chk("t1_new_dat", 32'(m_new_dat), 32'd1);
    chk("t1_m_addr",  32'(m_addr), 32'h78);
    chk("t1_m_dat",   32'(m_dat_in), 32'hFF);
    chk("t1_m_rw",    32'(m_r_w), 32'd0);
    chk("t1_busy",    32'(arb_busy), 32'd1);
    wait_rsp("t1", 3'd0, 2'b00, 8'h00);
    chk("t1_addr_hold", 32'(m_addr), 32'h78);
    chk("t1_launches",  32'(n_launch - l0), 32'd1);
    chk("t1_grants",    32'(n_gnt - g0), 32'd1);

    // T3: read from requester 1, master returns 0xA5.
    busy_len = 7; cfg_rdata = 8'hA5; l0 = n_launch;
    @(posedge clk); #1 post(1, 7'h48, 1'b1, 8'h00);
    wait_gnt("t3_gnt", 4'b0010, seen);
    drop(seen);
    @(negedge clk);
    chk("t3_m_rw", 32'(m_r_w), 32'd1);
    wait_rsp("t3", 3'd1, 2'b00, 8'hA5);
    chk("t3_launches", 32'(n_launch - l0), 32'd1);

    // Write from requester 3 moves the round-robin pointer to 3.
    busy_len = 3;
    @(posedge clk); #1 post(3, 7'h50, 1'b0, 8'hC3);
    wait_gnt("t3b_gnt", 4'b1000, seen);
    drop(seen);
    wait_rsp("t3b", 3'd3, 2'b00, 8'h00);
    chk("t3b_m_dat", 32'(m_dat_in), 32'hC3);

    // T2: requesters 0 and 2 together, each re-requests -> 0, 2, 0, 2.
    busy_len = 5;
    @(posedge clk); #1;
    post(0, 7'h10, 1'b0, 8'h11);
    post(2, 7'h22, 1'b0, 8'h33);
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("t2_gnt%0d", k), fair_gnt[k], seen);
      drop(seen);
      wait_rsp($sformatf("t2_rsp%0d", k), fair_id[k], 2'b00, 8'h00);
      @(posedge clk); #1;
      if (k < 2) post(int'(fair_id[k]), 7'h10, 1'b0, 8'h11);
    end

    // T4: master always NACKs -> 1 + 2 retries, then status 01, rdata 0.
    busy_len = 3; cfg_ack_err = 1'b1; cfg_rdata = 8'h5A; l0 = n_launch;
    post(1, 7'h2A, 1'b1, 8'h00);
    wait_gnt("t4_gnt", 4'b0010, seen);
    drop(seen);
    wait_rsp("t4", 3'd1, 2'b01, 8'h00);
    chk("t4_launches", 32'(n_launch - l0), 32'd3);
    chk("t4_addr_hold", 32'(m_addr), 32'h2A);
    chk("t4_rw_hold",   32'(m_r_w), 32'd1);
    cfg_ack_err = 1'b0;

    // T6: reset during WAIT_LO, req[3] pending; aborted txn never responds.
    busy_len = 40; cfg_rdata = 8'h00;
    @(posedge clk); #1 post(0, 7'h11, 1'b0, 8'h22);
    wait_gnt("t6_gnt0", 4'b0001, seen);
    drop(seen);
    post(3, 7'h33, 1'b0, 8'h44);
    repeat (10) @(negedge clk);
    chk("t6_wait_busy", 32'(arb_busy), 32'd1);
    chk("t6_no_gnt",    32'(gnt), 32'd0);
    r0 = n_rsp;
    rst = 1'b0;
    #1;
    chk("t6_rst_gnt",      32'(gnt), 32'd0);
    chk("t6_rst_valid",    32'(rsp_valid), 32'd0);
    chk("t6_rst_new_dat",  32'(m_new_dat), 32'd0);
    chk("t6_rst_m_addr",   32'(m_addr), 32'd0);
    chk("t6_rst_m_dat",    32'(m_dat_in), 32'd0);
    chk("t6_rst_busy",     32'(arb_busy), 32'd0);
    chk("t6_rst_status",   32'(rsp_status), 32'd0);
    chk("t6_rst_rsp_id",   32'(rsp_id), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_gnt("t6_gnt3", 4'b1000, seen);
    drop(seen);
    wait_rsp("t6", 3'd3, 2'b00, 8'h00);
    @(posedge clk); #1;
    chk("t6_rsp_count", 32'(n_rsp - r0), 32'd1);

    // T5: TIMEOUT=16 instance, master never raises busy.
    to_req_addr = {{(7*NREQ-7){1'b0}}, 7'h6E};
    to_req_rw   = 4'b0001;
    to_req      = 4'b0001;
    seen = '0;
    for (int c = 0; c < 50 && seen == '0; c++) begin
      @(negedge clk);
      seen = to_gnt;
    end
    chk("t5_gnt", 32'(seen), 32'h1);
    @(posedge clk); #1 to_req = '0;
    @(negedge clk);
    chk("t5_new_dat", 32'(to_m_new_dat), 32'd1);
    lat = 0;
    while (!to_rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_latency_window", 32'(lat >= 16 && lat <= 17), 32'd1);
    chk("t5_valid",  32'(to_rsp_valid), 32'd1);
    chk("t5_status", 32'(to_rsp_status), 32'h2);
    chk("t5_rdata",  32'(to_rsp_rdata), 32'd0);
    chk("t5_id",     32'(to_rsp_id), 32'd0);
    @(negedge clk);
    chk("t5_new_dat_low", 32'(to_m_new_dat), 32'd0);
    chk("t5_idle",        32'(to_arb_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one i2cmaster instance between NREQ requesters (sensor pollers, config loaders).
- Each requester posts one single-byte I2C transaction (7-bit address, R/W, write byte).
- The block grants requesters round-robin, launches the transaction on the master via new_dat/busy, and retries on ACK error.
- It returns read data and a status code per transaction through a shared response port.

Parameters:
- NREQ, 4, number of requesters (2..8)
- MAX_RETRY, 2, extra attempts after an ACK error (0 = no retry)
- TIMEOUT, 65535, cycle limit per wait phase before abort (fits 16-bit counter)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held until matching gnt pulse
- req_addr  in  7*NREQ  slave address, requester i at [7i+6:7i]
- req_rw  in  NREQ  1 = read, 0 = write
- req_wdata  in  8*NREQ  write byte, requester i at [8i+7:8i]
- gnt  out  NREQ  one-hot, 1-cycle acceptance pulse; request fields latched that cycle
- rsp_valid  out  1  1-cycle completion pulse
- rsp_id  out  3  index of completed requester, valid with rsp_valid
- rsp_status  out  2  00 ok, 01 NACK after retries, 10 timeout
- rsp_rdata  out  8  read byte; 0 for writes and for non-ok status
- m_new_dat  out  1  to master new_dat
- m_addr  out  7  to master addr
- m_r_w  out  1  to master r_w
- m_dat_in  out  8  to master dat_in
- m_dat_out  in  8  from master dat_out
- m_busy  in  1  from master busy
- m_ack_err  in  1  from master ack_err
- arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async) clears all outputs, gnt, rsp_*, m_* and counters to 0. State -> IDLE. last_id -> NREQ-1, so requester 0 has highest priority first.
- m_addr, m_r_w, m_dat_in are driven from the latched registers and stay stable for the whole transaction, including retries.
- IDLE:
  - If any req bit is set, select the first set bit scanning last_id+1, last_id+2, ... modulo NREQ.
  - Pulse gnt[sel] and latch addr/rw/wdata/id. Clear retry_cnt. Go to LAUNCH next cycle.
  - Requester deasserts req on the cycle after gnt. A req dropped before gnt is simply not served.
- LAUNCH: m_new_dat=1, timer=0. Go to WAIT_HI.
- WAIT_HI:
  - m_new_dat held at 1; timer increments.
  - If m_busy=1: m_new_dat=0 next cycle, timer=0, go to WAIT_LO.
  - Else if timer==TIMEOUT-1: status=10, go to RESP.
- WAIT_LO:
  - m_new_dat=0; timer increments.
  - If m_busy=0: capture m_ack_err and m_dat_out, go to CHECK.
  - Else if timer==TIMEOUT-1: status=10, go to RESP.
- CHECK:
  - ack_err=1 and retry_cnt<MAX_RETRY: retry_cnt+1, go to LAUNCH.
  - ack_err=1 and retries exhausted: status=01, go to RESP.
  - Else: status=00, rdata=captured byte if read, else 0. Go to RESP.
- RESP: rsp_valid=1 for one cycle with rsp_id/rsp_status/rsp_rdata. last_id=id. Go to IDLE. rsp_* hold their values until the next RESP.
- Latency from gnt to rsp_valid: 1 + per-attempt (2 + busy-rise delay + busy duration + 1) + 1 cycles.
- New requests arriving while not IDLE wait; no grant is issued until the next IDLE cycle.
- A req held continuously by the same requester is served again only after every other pending requester has been served once (fairness).
- Reset mid-transaction aborts without rsp_valid. The master is reset by the same rst.

Test Plan:
- req[0], write addr 7'h78, wdata 8'hFF; master model holds busy 40 cycles, ack_err=0 -> gnt=0001 once, one m_new_dat launch, rsp_valid with id 0, status 00, rdata 0.
- req[0] and req[2] asserted same cycle, both re-request after completion -> grant order 0, 2, 0, 2; never 0 twice in a row while 2 pending.
- Read request from requester 1, model returns m_dat_out=8'hA5 -> rsp_id 1, status 00, rdata 8'hA5.
- Model always returns ack_err=1, MAX_RETRY=2 -> exactly 3 m_new_dat launches, then status 01, rdata 0.
- Model never raises busy, TIMEOUT=16 -> rsp_valid 16 cycles after LAUNCH with status 10; m_new_dat low afterwards.
- rst pulsed low during WAIT_LO -> all outputs 0 immediately, no rsp_valid; after release, pending req[3] gets gnt as first grant only if req[0..2] idle.
